// File: rtl/ghyston_mem_pkg.sv
// Shared definitions for the Ghyston memory blocks: clear-sequencer states,
// legal read-latency bounds and the byte-lane count helper.
package ghyston_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int nlane(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks addresses 0..DEPTH-1 writing zero, then
// parks in READY until the next reset.
module ram_clear_seq
  import ghyston_mem_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_cnt == LAST_ADDR) begin
      w_state_nxt = READY;
    end
  end

  always_comb begin
    clr_we    = (r_state == CLEAR);
    clr_addr  = r_cnt;
    init_busy = (r_state == CLEAR);
  end

endmodule

// File: rtl/ram_bytewe_sdp.sv
// Simple-dual-port RAM with active-low byte-lane write selects, byte-granular
// write-first forwarding, 1- or 2-cycle read latency and a post-reset clear.
module ram_bytewe_sdp
  import ghyston_mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 13,
  parameter  int DEPTH  = 8192,
  parameter  int RD_LAT = 1,
  localparam int NLANE  = nlane(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NLANE-1:0]  wr_cs_b,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("ram_bytewe_sdp: RD_LAT must be 1 or 2");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
      $error("ram_bytewe_sdp: DATA_W must be a positive multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("ram_bytewe_sdp: DEPTH must lie in 2..2**ADDR_W");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] fwd_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NLANE-1:0]  sel
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NLANE; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_busy;
  logic [NLANE-1:0]  w_lane_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_waddr_ok;
  logic              w_raddr_ok;
  logic              w_rd_req;
  logic              w_fwd_hit;
  logic [NLANE-1:0]  w_fwd_lanes;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_busy (w_busy)
  );

  // Clear sequencer owns the write port until it finishes; user writes are dropped.
  always_comb begin
    if (w_clr_we) begin
      w_lane_we = '1;
      w_waddr   = w_clr_addr;
      w_wdata   = '0;
    end else begin
      w_lane_we = ~wr_cs_b;
      w_waddr   = wr_addr;
      w_wdata   = wr_data;
    end
  end

  assign w_waddr_ok = ({1'b0, w_waddr} < DEPTH_V);

  always_ff @(posedge clk) begin
    if (w_waddr_ok) begin
      for (int i = 0; i < NLANE; i++) begin
        if (w_lane_we[i]) begin
          r_mem[w_waddr[IDX_W-1:0]][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage p0: sample the read word, overlaying bytes written in this same cycle.
  assign w_raddr_ok  = ({1'b0, rd_addr} < DEPTH_V);
  assign w_rd_req    = rd_en && !w_busy;
  assign w_fwd_hit   = !w_busy && (wr_addr == rd_addr);
  assign w_fwd_lanes = w_fwd_hit ? ~wr_cs_b : '0;

  always_comb begin
    w_rd_word = '0;
    if (w_raddr_ok) begin
      w_rd_word = fwd_merge(r_mem[rd_addr[IDX_W-1:0]], wr_data, w_fwd_lanes);
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_rd_req;
          if (w_rd_req) begin
            r_rd_data <= w_rd_word;
          end
        end
      end
    end else begin : g_lat2
      logic              r_vld_p0;
      logic [DATA_W-1:0] r_data_p0;

      always_ff @(posedge clk) begin
        if (w_rd_req) begin
          r_data_p0 <= w_rd_word;
        end
      end

      // Stage p1: output register, loaded only when a result is in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld_p0   <= 1'b0;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_vld_p0   <= w_rd_req;
          r_rd_valid <= r_vld_p0;
          if (r_vld_p0) begin
            r_rd_data <= r_data_p0;
          end
        end
      end
    end
  endgenerate

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign init_busy = w_busy;

endmodule

// File: tb/tb_ram_bytewe_sdp.sv
// Directed bench for ram_bytewe_sdp: three instances cover RD_LAT=1,
// RD_LAT=2 and a non-power-of-two depth with out-of-range addresses.
module tb_ram_bytewe_sdp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 1: DEPTH=16, RD_LAT=1
  logic        rst1 = 1'b1;
  logic [4:0]  wa1 = '0, ra1 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0]  cs1 = 4'hF;
  logic        re1 = 1'b0;
  logic [31:0] rd1;
  logic        rv1, ib1;

  // Instance 2: DEPTH=16, RD_LAT=2
  logic        rst2 = 1'b1;
  logic [4:0]  wa2 = '0, ra2 = '0;
  logic [31:0] wd2 = '0;
  logic [3:0]  cs2 = 4'hF;
  logic        re2 = 1'b0;
  logic [31:0] rd2;
  logic        rv2, ib2;

  // Instance 3: DEPTH=12, ADDR_W=4, RD_LAT=1
  logic        rst3 = 1'b1;
  logic [3:0]  wa3 = '0, ra3 = '0;
  logic [31:0] wd3 = '0;
  logic [3:0]  cs3 = 4'hF;
  logic        re3 = 1'b0;
  logic [31:0] rd3;
  logic        rv3, ib3;

  ram_bytewe_sdp #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .wr_addr(wa1), .wr_data(wd1), .wr_cs_b(cs1),
    .rd_en(re1), .rd_addr(ra1), .rd_data(rd1), .rd_valid(rv1), .init_busy(ib1)
  );

  ram_bytewe_sdp #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(rst2), .wr_addr(wa2), .wr_data(wd2), .wr_cs_b(cs2),
    .rd_en(re2), .rd_addr(ra2), .rd_data(rd2), .rd_valid(rv2), .init_busy(ib2)
  );

  ram_bytewe_sdp #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(1)) u_dut3 (
    .clk(clk), .reset(rst3), .wr_addr(wa3), .wr_data(wd3), .wr_cs_b(cs3),
    .rd_en(re3), .rd_addr(ra3), .rd_data(rd3), .rd_valid(rv3), .init_busy(ib3)
  );

  typedef struct {
    logic [3:0]  cs;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] cs, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re, input logic [4:0] ra,
                              input logic ev, input logic [31:0] ed);
    vec_t v;
    v.cs = cs; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_vld;

    // Vector table for instance 1 (results visible right after the sampling edge).
    for (int a = 0; a < 16; a++) vt.push_back(mk(4'hF, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 32'h0));
    vt.push_back(mk(4'b0000, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'h0));
    vt.push_back(mk(4'b1010, 5'd5,  32'h11223344, 1'b0, 5'd0,  1'b0, 32'h0));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 32'hDE22BE44));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'hDE22BE44));
    // Lanes 1:0 written in the same cycle as the read: forwarded bytes.
    vt.push_back(mk(4'b1100, 5'd5,  32'hCAFEF00D, 1'b1, 5'd5,  1'b1, 32'hDE22F00D));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 32'hDE22F00D));
    vt.push_back(mk(4'b0000, 5'd15, 32'hA1B2C3D4, 1'b1, 5'd14, 1'b1, 32'h0));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b1, 5'd15, 1'b1, 32'hA1B2C3D4));
    vt.push_back(mk(4'b0000, 5'd20, 32'hFFFFFFFF, 1'b1, 5'd20, 1'b1, 32'h0));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 32'h0));
    vt.push_back(mk(4'hF,    5'd6,  32'hFFFFFFFF, 1'b1, 5'd6,  1'b1, 32'h0));
    vt.push_back(mk(4'hF,    5'd0,  32'h0,        1'b1, 5'd6,  1'b1, 32'h0));

    repeat (2) tick();
    chk("reset_rd_data1", rd1, 32'h0);
    chk("reset_rd_valid1", {31'h0, rv1}, 32'h0);
    chk("reset_init_busy1", {31'h0, ib1}, 32'h1);
    chk("reset_rd_data2", rd2, 32'h0);
    chk("reset_rd_valid2", {31'h0, rv2}, 32'h0);

    // Instance 1: reset re-asserted at cycle 7 of the clear sequence.
    rst1 = 1'b0;
    repeat (7) tick();
    chk("busy_mid_clear", {31'h0, ib1}, 32'h1);
    rst1 = 1'b1;
    tick();
    chk("busy_in_reset", {31'h0, ib1}, 32'h1);
    rst1 = 1'b0;
    re1 = 1'b1;
    ra1 = 5'd3;
    n = 0;
    seen_vld = 1'b0;
    while (ib1 && n < 100) begin
      tick();
      n++;
      if (rv1 !== 1'b0) seen_vld = 1'b1;
    end
    chk("init_len1", n, 16);
    chk("clear_no_rdvalid", {31'h0, seen_vld}, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      cs1 = vt[i].cs; wa1 = vt[i].wa; wd1 = vt[i].wd; re1 = vt[i].re; ra1 = vt[i].ra;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'h0, rv1}, {31'h0, vt[i].ev});
      chk($sformatf("vec%0d_data", i), rd1, vt[i].ed);
    end
    cs1 = 4'hF; re1 = 1'b0;

    // Instance 2: RD_LAT=2 pipeline behaviour.
    rst2 = 1'b0;
    n = 0;
    while (ib2 && n < 100) begin
      tick();
      n++;
    end
    chk("init_len2", n, 16);
    for (int a = 1; a <= 3; a++) begin
      cs2 = 4'b0000; wa2 = 5'(a); wd2 = {4{8'(a)}};
      tick();
    end
    cs2 = 4'hF;
    re2 = 1'b1; ra2 = 5'd1;
    tick();
    chk("lat2_e1_valid", {31'h0, rv2}, 32'h0);
    ra2 = 5'd2; cs2 = 4'b0000; wa2 = 5'd1; wd2 = 32'hEEEEEEEE;
    tick();
    chk("lat2_e2_valid", {31'h0, rv2}, 32'h1);
    chk("lat2_e2_data", rd2, 32'h01010101);
    ra2 = 5'd3; cs2 = 4'hF;
    tick();
    chk("lat2_e3_valid", {31'h0, rv2}, 32'h1);
    chk("lat2_e3_data", rd2, 32'h02020202);
    re2 = 1'b0;
    tick();
    chk("lat2_e4_valid", {31'h0, rv2}, 32'h1);
    chk("lat2_e4_data", rd2, 32'h03030303);
    tick();
    chk("lat2_idle_valid", {31'h0, rv2}, 32'h0);
    chk("lat2_hold_data", rd2, 32'h03030303);
    re2 = 1'b1; ra2 = 5'd1;
    tick();
    re2 = 1'b0;
    tick();
    chk("lat2_wr_landed", rd2, 32'hEEEEEEEE);
    // Forward lane 0 at the sampling edge, then overwrite the word next cycle.
    re2 = 1'b1; ra2 = 5'd2; cs2 = 4'b1110; wa2 = 5'd2; wd2 = 32'h00000099;
    tick();
    re2 = 1'b0; cs2 = 4'b0000; wd2 = 32'h77777777;
    tick();
    cs2 = 4'hF;
    chk("lat2_fwd_valid", {31'h0, rv2}, 32'h1);
    chk("lat2_fwd_data", rd2, 32'h02020299);
    // Reset while a read is in flight.
    re2 = 1'b1; ra2 = 5'd3;
    tick();
    re2 = 1'b0;
    #2 rst2 = 1'b1;
    tick();
    chk("rst_pending_valid", {31'h0, rv2}, 32'h0);
    chk("rst_pending_data", rd2, 32'h0);
    chk("rst_pending_busy", {31'h0, ib2}, 32'h1);
    rst2 = 1'b0;
    n = 0;
    seen_vld = 1'b0;
    while (ib2 && n < 100) begin
      tick();
      n++;
      if (rv2 !== 1'b0) seen_vld = 1'b1;
    end
    chk("init_len2_after_rst", n, 16);
    chk("rst_no_late_valid", {31'h0, seen_vld}, 32'h0);

    // Instance 3: DEPTH=12 with out-of-range accesses; user writes during clear.
    rst3 = 1'b0;
    cs3 = 4'b0000; wa3 = 4'd0; wd3 = 32'hFFFFFFFF;
    n = 0;
    while (ib3 && n < 100) begin
      tick();
      n++;
    end
    chk("init_len3", n, 12);
    cs3 = 4'b0000; wa3 = 4'd3; wd3 = 32'h12345678;
    tick();
    wa3 = 4'd13; wd3 = 32'hFFFFFFFF;
    tick();
    wa3 = 4'd12;
    tick();
    cs3 = 4'hF; re3 = 1'b1; ra3 = 4'd3;
    tick();
    chk("d12_rd3", rd3, 32'h12345678);
    ra3 = 4'd13;
    tick();
    chk("d12_oor_valid", {31'h0, rv3}, 32'h1);
    chk("d12_oor_data", rd3, 32'h0);
    for (int a = 0; a < 12; a++) begin
      ra3 = 4'(a);
      tick();
      chk($sformatf("d12_addr%0d", a), rd3, (a == 3) ? 32'h12345678 : 32'h0);
    end
    re3 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
